display_scanner: RTL and testbench

Time-multiplexing scanner that sits directly upstream of the 7-segment decoder. It holds a multi-digit value and selects one digit column at a time. For each column it presents that column's 4-bit nibble and a segment enable to the decoder, and drives the active-low column select lines. New values are double-buffered and only committed at frame boundaries, so no frame ever shows a mix of old and new digits.

---
 rtl/display_scanner.sv | 178 +++++++++++++++++
 tb/tb_display_scanner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Time-multiplexed digit scanner feeding a 7-segment decoder, with frame-aligned double buffering.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (column 0 always lit).
module display_scanner #(
    parameter int TOTAL_COLUNES  = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int PRESCALE       = 50000,
    parameter int PRESCALE_WIDTH = 16,
    parameter int BLANK_CYCLES   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     load,
    output logic [3:0]               binary_code,
    output logic                     enable,
    output logic [TOTAL_COLUNES-1:0] colune_select,
    output logic                     pending,
    output logic                     frame_done
);

    localparam int DIGIT_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;
    localparam logic [PRESCALE_WIDTH-1:0] TICK_VAL   = PRESCALE_WIDTH'(PRESCALE - 1);
    localparam logic [PRESCALE_WIDTH-1:0] BLANK_END  = PRESCALE_WIDTH'(BLANK_CYCLES - 1);
    localparam logic [DIGIT_W-1:0]        LAST_DIGIT = DIGIT_W'(TOTAL_COLUNES - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    state_t                    state_r;
    logic [PRESCALE_WIDTH-1:0] slot_cnt_r;
    logic [DIGIT_W-1:0]        digit_r;
    logic [DATA_WIDTH-1:0]     shadow_r;
    logic [DATA_WIDTH-1:0]     staged_r;

    state_t                    nxt_state_s;
    logic [PRESCALE_WIDTH-1:0] nxt_slot_s;
    logic [DIGIT_W-1:0]        nxt_digit_s;
    logic [DATA_WIDTH-1:0]     nxt_shadow_s;
    logic [DATA_WIDTH-1:0]     nxt_staged_s;
    logic                      nxt_pending_s;
    logic                      nxt_frame_s;
    logic                      tick_s;
    logic                      boundary_s;
    logic [3:0]                nxt_code_s;
    logic                      nxt_enable_s;
    logic [TOTAL_COLUNES-1:0]  nxt_select_s;

    function automatic logic [3:0] nibble_at(input logic [DATA_WIDTH-1:0] word,
                                             input logic [DIGIT_W-1:0] idx);
        logic [3:0] nib;
        nib = 4'h0;
        for (int i = 0; i < TOTAL_COLUNES; i++) begin
            if (int'(idx) == i) begin
                nib = word[4*i +: 4];
            end else begin
                nib = nib;
            end
        end
        return nib;
    endfunction

    // True when column idx and every column above it hold zero; column 0 never qualifies.
    function automatic logic leading_zero(input logic [DATA_WIDTH-1:0] word,
                                          input logic [DIGIT_W-1:0] idx);
        logic blank;
        blank = (idx != '0);
        for (int i = 0; i < TOTAL_COLUNES; i++) begin
            if (i >= int'(idx) && word[4*i +: 4] != 4'h0) begin
                blank = 1'b0;
            end else begin
                blank = blank;
            end
        end
        return blank;
    endfunction

    // Next-state, buffer-commit and next-output computation.
    always_comb begin
        nxt_state_s   = state_r;
        nxt_slot_s    = slot_cnt_r;
        nxt_digit_s   = digit_r;
        nxt_shadow_s  = shadow_r;
        nxt_staged_s  = staged_r;
        nxt_pending_s = pending;
        nxt_frame_s   = 1'b0;
        tick_s        = (slot_cnt_r == TICK_VAL);
        boundary_s    = (state_r == ON) && tick_s && (digit_r == LAST_DIGIT);

        if (!run || state_r == OFF) begin
            nxt_state_s = run ? BLANK : OFF;
            nxt_slot_s  = '0;
            nxt_digit_s = '0;
            nxt_frame_s = run;
            // Direct load wins; otherwise flush any staged word on the way into OFF.
            if (load) begin
                nxt_shadow_s  = data_in;
                nxt_pending_s = 1'b0;
            end else if (pending) begin
                nxt_shadow_s  = staged_r;
                nxt_pending_s = 1'b0;
            end else begin
                nxt_pending_s = 1'b0;
            end
        end else begin
            nxt_slot_s  = tick_s ? '0 : slot_cnt_r + PRESCALE_WIDTH'(1);
            nxt_frame_s = boundary_s;
            case (state_r)
                BLANK: nxt_state_s = (slot_cnt_r == BLANK_END) ? ON : BLANK;
                ON: begin
                    if (tick_s) begin
                        nxt_state_s = BLANK;
                        nxt_digit_s = (digit_r == LAST_DIGIT) ? '0 : digit_r + DIGIT_W'(1);
                    end else begin
                        nxt_state_s = ON;
                    end
                end
                default: nxt_state_s = OFF;
            endcase
            if (boundary_s && load) begin
                nxt_shadow_s  = data_in;
                nxt_pending_s = 1'b0;
            end else if (boundary_s && pending) begin
                nxt_shadow_s  = staged_r;
                nxt_pending_s = 1'b0;
            end else if (load) begin
                nxt_staged_s  = data_in;
                nxt_pending_s = 1'b1;
            end else begin
                nxt_pending_s = pending;
            end
        end

        nxt_code_s = (nxt_state_s == OFF) ? 4'h0 : nibble_at(nxt_shadow_s, nxt_digit_s);
`ifdef LEADING_ZERO_BLANK_EN
        nxt_enable_s = (nxt_state_s == ON) && !leading_zero(nxt_shadow_s, nxt_digit_s);
`else
        nxt_enable_s = (nxt_state_s == ON);
`endif
        for (int i = 0; i < TOTAL_COLUNES; i++) begin
            nxt_select_s[i] = !((nxt_state_s != OFF) && (int'(nxt_digit_s) == i));
        end
    end

    // State, buffers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= OFF;
            slot_cnt_r    <= '0;
            digit_r       <= '0;
            shadow_r      <= '0;
            staged_r      <= '0;
            pending       <= 1'b0;
            binary_code   <= 4'h0;
            enable        <= 1'b0;
            colune_select <= '1;
            frame_done    <= 1'b0;
        end else begin
            state_r       <= nxt_state_s;
            slot_cnt_r    <= nxt_slot_s;
            digit_r       <= nxt_digit_s;
            shadow_r      <= nxt_shadow_s;
            staged_r      <= nxt_staged_s;
            pending       <= nxt_pending_s;
            binary_code   <= nxt_code_s;
            enable        <= nxt_enable_s;
            colune_select <= nxt_select_s;
            frame_done    <= nxt_frame_s;
        end
    end

    logic unused_s;
    assign unused_s = ^{leading_zero(shadow_r, digit_r)};

endmodule

// File: tb/tb_display_scanner.sv
// Directed scoreboard bench for display_scanner at PRESCALE=4, BLANK_CYCLES=1, four columns.
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [15:0] data_in;
    logic        load;
    logic [3:0]  binary_code;
    logic        enable;
    logic [3:0]  colune_select;
    logic        pending;
    logic        frame_done;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] code;
        logic       en;
        logic       pend;
        logic       fd;
    } obs_t;

    obs_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    display_scanner #(
        .TOTAL_COLUNES(4), .DATA_WIDTH(16), .PRESCALE(4),
        .PRESCALE_WIDTH(16), .BLANK_CYCLES(1)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .data_in(data_in), .load(load),
        .binary_code(binary_code), .enable(enable), .colune_select(colune_select),
        .pending(pending), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [3:0] sel, input logic [3:0] code,
                        input logic en, input logic pend, input logic fd);
        obs_t e;
        e = {sel, code, en, pend, fd};
        exp_q.push_back(e);
    endtask

    task automatic check_now(input string tag);
        obs_t got;
        obs_t want;
        want = exp_q.pop_front();
        got  = {colune_select, binary_code, enable, pending, frame_done};
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed sel=%b code=%h en=%b pend=%b fd=%b, expected sel=%b code=%h en=%b pend=%b fd=%b",
                   tag, got.sel, got.code, got.en, got.pend, got.fd,
                   want.sel, want.code, want.en, want.pend, want.fd);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [3:0] sel, input logic [3:0] code,
                                input logic en, input logic pend, input logic fd);
        push(sel, code, en, pend, fd);
        @(posedge clk);
        #1;
        check_now(tag);
    endtask

    // One full column slot: 1 dark cycle then 3 lit cycles; optional load driven before cycle load_at.
    task automatic slot(input int d, input logic [3:0] code, input logic lit,
                        input logic [3:0] pend, input logic fd,
                        input int load_at, input logic [15:0] load_val);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << d;
        for (int k = 0; k < 4; k++) begin
            if (k == load_at) begin
                load    = 1'b1;
                data_in = load_val;
            end
            expect_cycle($sformatf("d%0d.%0d", d, k), ~one_hot, code,
                         (k != 0) && lit, pend[k], (k == 0) && fd);
            load = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; load = 1'b0; data_in = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        push(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        check_now("reset");
        reset = 1'b0;

        // Load while dark, then scan 0x1234.
        load = 1'b1; data_in = 16'h1234;
        expect_cycle("load_off", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; run = 1'b1;
        slot(0, 4'h4, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        slot(1, 4'h3, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(2, 4'h2, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(3, 4'h1, 1'b1, 4'b0000, 1'b0, -1, 16'h0);

        // Staged load during digit 1 commits at the next frame.
        slot(0, 4'h4, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        slot(1, 4'h3, 1'b1, 4'b1110, 1'b0, 1, 16'hABCD);
        slot(2, 4'h2, 1'b1, 4'b1111, 1'b0, -1, 16'h0);
        slot(3, 4'h1, 1'b1, 4'b1111, 1'b0, -1, 16'h0);
        slot(0, 4'hD, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        slot(1, 4'hC, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(2, 4'hB, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(3, 4'hA, 1'b1, 4'b0000, 1'b0, -1, 16'h0);

        // Two loads in one frame: last wins.
        slot(0, 4'hD, 1'b1, 4'b1100, 1'b1, 2, 16'h1111);
        slot(1, 4'hC, 1'b1, 4'b1111, 1'b0, 1, 16'h2222);
        slot(2, 4'hB, 1'b1, 4'b1111, 1'b0, -1, 16'h0);
        slot(3, 4'hA, 1'b1, 4'b1111, 1'b0, -1, 16'h0);
        slot(0, 4'h2, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        slot(1, 4'h2, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(2, 4'h2, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(3, 4'h2, 1'b1, 4'b0000, 1'b0, -1, 16'h0);

        // Load exactly on the frame-boundary tick goes straight to the display.
        slot(0, 4'h8, 1'b1, 4'b0000, 1'b1, 0, 16'h5678);
        slot(1, 4'h7, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(2, 4'h6, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(3, 4'h5, 1'b1, 4'b0000, 1'b0, -1, 16'h0);

        // Run drops mid-slot with a word pending; restart, then async reset.
        slot(0, 4'h8, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        slot(1, 4'h7, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        expect_cycle("d2_blank", 4'b1011, 4'h6, 1'b0, 1'b0, 1'b0);
        load = 1'b1; data_in = 16'h9ABC;
        expect_cycle("d2_on_load", 4'b1011, 4'h6, 1'b1, 1'b1, 1'b0);
        load = 1'b0; run = 1'b0;
        expect_cycle("run_off", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        expect_cycle("stay_off", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        run = 1'b1;
        slot(0, 4'hC, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        expect_cycle("d1_blank", 4'b1101, 4'hB, 1'b0, 1'b0, 1'b0);
        expect_cycle("d1_on", 4'b1101, 4'hB, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        push(4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        check_now("async_reset");
        run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Leading-zero handling for 0x0040.
        load = 1'b1; data_in = 16'h0040;
        expect_cycle("load_0040", 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        load = 1'b0; run = 1'b1;
        slot(0, 4'h0, 1'b1, 4'b0000, 1'b1, -1, 16'h0);
        slot(1, 4'h4, 1'b1, 4'b0000, 1'b0, -1, 16'h0);
        slot(2, 4'h0, !LZ, 4'b0000, 1'b0, -1, 16'h0);
        slot(3, 4'h0, !LZ, 4'b0000, 1'b0, -1, 16'h0);
        run = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
